// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request bundle and EX-stage forwarding/stall response of the
// hazard unit. The pipeline (master) drives the ID fields, the hazard unit
// (slave) answers combinationally in the same cycle.
//
// Handshake: id_valid qualifies every id_* field. stall acts as a
// not-ready: while it is high the ID instruction is not accepted, and the
// master must present the same ID instruction again in the next cycle.
// hold freezes both sides; flush withdraws the ID instruction.
interface fwd_hazard_unit_if #(
    parameter int REG_AW = 4,
    parameter int SELW   = 2,
    parameter int CNT_W  = 16
);
    logic              hold;
    logic              flush;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              stall;
    logic [SELW-1:0]   fwd_a;
    logic [SELW-1:0]   fwd_b;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output hold, flush, id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_regwrite, id_memread,
        input  stall, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  hold, flush, id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_regwrite, id_memread,
        output stall, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit. Keeps a shadow copy of the writers
// in flight (slot0 = EX, slot1..NUM_STAGES = later stages), derives the
// operand forwarding selects for the EX instruction, requests a stall for
// load-use hazards seen in ID, and counts stall cycles (saturating).
module fwd_hazard_unit #(
    parameter  int REG_AW     = 4,
    parameter  int NUM_STAGES = 2,
    parameter  int LOAD_STAGE = 2,
    parameter  int ZERO_REG   = 1,
    parameter  int CNT_W      = 16,
    localparam int SELW       = $clog2(NUM_STAGES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    fwd_hazard_unit_if.slave    bus
);

    // Writer state for every slot
    logic              slotValid    [0:NUM_STAGES];
    logic [REG_AW-1:0] slotRd       [0:NUM_STAGES];
    logic              slotRegwrite [0:NUM_STAGES];
    logic              slotMemread  [0:NUM_STAGES];

    // Source operands of the EX instruction (slot0 only)
    logic [REG_AW-1:0] slot0Rs;
    logic [REG_AW-1:0] slot0Rt;
    logic              slot0RsUsed;
    logic              slot0RtUsed;

    logic              stallReq;
    logic [SELW-1:0]   fwdA;
    logic [SELW-1:0]   fwdB;
    logic [CNT_W-1:0]  stallCnt;

    // A slot produces register src; register 0 is hard-wired when ZERO_REG
    function automatic logic isWriter(input logic v, input logic rw,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] src);
        return v && rw && (rd == src) && !((ZERO_REG != 0) && (src == '0));
    endfunction

    // Forward selects: nearest producer wins; a load that is not yet
    // forwardable yields the register file (a stall already covered it)
    always_comb begin
        logic [SELW-1:0] selA;
        logic [SELW-1:0] selB;
        logic            ldA;
        logic            ldB;
        selA = '0;
        selB = '0;
        ldA  = 1'b0;
        ldB  = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (slot0RsUsed && isWriter(slotValid[k], slotRegwrite[k], slotRd[k], slot0Rs)) begin
                selA = SELW'(k);
                ldA  = slotMemread[k];
            end
            if (slot0RtUsed && isWriter(slotValid[k], slotRegwrite[k], slotRd[k], slot0Rt)) begin
                selB = SELW'(k);
                ldB  = slotMemread[k];
            end
        end
        fwdA = (ldA && (int'(selA) < LOAD_STAGE)) ? '0 : selA;
        fwdB = (ldB && (int'(selB) < LOAD_STAGE)) ? '0 : selB;
    end

    // Load-use detection: the nearest writer within the not-yet-forwardable
    // window decides; a nearer non-load masks an older load
    always_comb begin
        logic ldRs;
        logic ldRt;
        ldRs = 1'b0;
        ldRt = 1'b0;
        for (int j = NUM_STAGES; j >= 0; j--) begin
            if (j < LOAD_STAGE - 1) begin
                if (isWriter(slotValid[j], slotRegwrite[j], slotRd[j], bus.id_rs)) begin
                    ldRs = slotMemread[j];
                end
                if (isWriter(slotValid[j], slotRegwrite[j], slotRd[j], bus.id_rt)) begin
                    ldRt = slotMemread[j];
                end
            end
        end
        stallReq = bus.id_valid && !bus.flush &&
                   ((bus.id_rs_used && ldRs) || (bus.id_rt_used && ldRt));
    end

    // Shadow pipeline: shift writers down, admit ID or a bubble into slot0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NUM_STAGES; k++) begin
                slotValid[k]    <= 1'b0;
                slotRd[k]       <= '0;
                slotRegwrite[k] <= 1'b0;
                slotMemread[k]  <= 1'b0;
            end
            slot0Rs     <= '0;
            slot0Rt     <= '0;
            slot0RsUsed <= 1'b0;
            slot0RtUsed <= 1'b0;
        end else if (!bus.hold) begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                slotValid[k]    <= slotValid[k-1];
                slotRd[k]       <= slotRd[k-1];
                slotRegwrite[k] <= slotRegwrite[k-1];
                slotMemread[k]  <= slotMemread[k-1];
            end
            if (!stallReq && !bus.flush) begin
                slotValid[0]    <= bus.id_valid;
                slotRd[0]       <= bus.id_rd;
                slotRegwrite[0] <= bus.id_regwrite;
                slotMemread[0]  <= bus.id_memread;
                slot0Rs         <= bus.id_rs;
                slot0Rt         <= bus.id_rt;
                slot0RsUsed     <= bus.id_rs_used;
                slot0RtUsed     <= bus.id_rt_used;
            end else begin
                // Bubble: nothing written, nothing read
                slotValid[0]    <= 1'b0;
                slotRd[0]       <= '0;
                slotRegwrite[0] <= 1'b0;
                slotMemread[0]  <= 1'b0;
                slot0Rs         <= '0;
                slot0Rt         <= '0;
                slot0RsUsed     <= 1'b0;
                slot0RtUsed     <= 1'b0;
            end
        end
    end

    // Saturating count of stall cycles that actually took effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (stallReq && !bus.hold && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign bus.stall     = stallReq;
    assign bus.fwd_a     = fwdA;
    assign bus.fwd_b     = fwdB;
    assign bus.stall_cnt = stallCnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: a default build driven from a vector table,
// and a NUM_STAGES=3 / LOAD_STAGE=3 / 2-bit-counter build driven by a
// hand-written sequence with an expected-value queue.
module tb_fwd_hazard_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_AW(4), .SELW(2), .CNT_W(16)) ifA ();
    fwd_hazard_unit_if #(.REG_AW(4), .SELW(2), .CNT_W(2))  ifB ();

    fwd_hazard_unit #(
        .REG_AW(4), .NUM_STAGES(2), .LOAD_STAGE(2), .ZERO_REG(1), .CNT_W(16)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .bus(ifA.slave)
    );

    fwd_hazard_unit #(
        .REG_AW(4), .NUM_STAGES(3), .LOAD_STAGE(3), .ZERO_REG(1), .CNT_W(2)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .bus(ifB.slave)
    );

    // ---------------- instruction records ----------------
    typedef struct packed {
        logic       v;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       rsu;
        logic       rtu;
        logic [3:0] rd;
        logic       rw;
        logic       mr;
    } instrT;

    typedef struct {
        string name;
        logic  hold;
        logic  flush;
        instrT ins;
        int    expStall;
        int    expA;
        int    expB;
        int    expCnt;
    } vecT;

    function automatic instrT nop();
        instrT i;
        i = '0;
        return i;
    endfunction

    function automatic instrT alu(input int rd, input int rs, input int rt);
        instrT i;
        i     = '0;
        i.v   = 1'b1;
        i.rs  = 4'(rs);
        i.rt  = 4'(rt);
        i.rsu = 1'b1;
        i.rtu = 1'b1;
        i.rd  = 4'(rd);
        i.rw  = 1'b1;
        return i;
    endfunction

    function automatic instrT ld(input int rd, input int base);
        instrT i;
        i     = '0;
        i.v   = 1'b1;
        i.rs  = 4'(base);
        i.rsu = 1'b1;
        i.rd  = 4'(rd);
        i.rw  = 1'b1;
        i.mr  = 1'b1;
        return i;
    endfunction

    // Not a real instruction but with a used source: reaches EX without
    // having been checked for load-use, exposing the early-load select rule
    function automatic instrT ghost(input int rs);
        instrT i;
        i     = '0;
        i.rs  = 4'(rs);
        i.rsu = 1'b1;
        return i;
    endfunction

    function automatic vecT mk(input string name, input logic hold, input logic flush,
                               input instrT ins, input int st, input int a,
                               input int b, input int cnt);
        vecT x;
        x.name     = name;
        x.hold     = hold;
        x.flush    = flush;
        x.ins      = ins;
        x.expStall = st;
        x.expA     = a;
        x.expB     = b;
        x.expCnt   = cnt;
        return x;
    endfunction

    // ---------------- scoreboard state ----------------
    int         nTests = 0;
    int         nFail  = 0;
    logic [6:0] expQ[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic driveA(input logic hold, input logic flush, input instrT ins);
        ifA.hold        = hold;
        ifA.flush       = flush;
        ifA.id_valid    = ins.v;
        ifA.id_rs       = ins.rs;
        ifA.id_rt       = ins.rt;
        ifA.id_rs_used  = ins.rsu;
        ifA.id_rt_used  = ins.rtu;
        ifA.id_rd       = ins.rd;
        ifA.id_regwrite = ins.rw;
        ifA.id_memread  = ins.mr;
    endtask

    task automatic driveB(input logic hold, input logic flush, input instrT ins);
        ifB.hold        = hold;
        ifB.flush       = flush;
        ifB.id_valid    = ins.v;
        ifB.id_rs       = ins.rs;
        ifB.id_rt       = ins.rt;
        ifB.id_rs_used  = ins.rsu;
        ifB.id_rt_used  = ins.rtu;
        ifB.id_rd       = ins.rd;
        ifB.id_regwrite = ins.rw;
        ifB.id_memread  = ins.mr;
    endtask

    // Compare dutB against the oldest queued expectation {stall,a,b,cnt}
    task automatic compareB(input string name);
        logic [6:0] exp;
        logic [6:0] got;
        got = {ifB.stall, ifB.fwd_a, ifB.fwd_b, ifB.stall_cnt};
        nTests++;
        if (expQ.size() == 0) begin
            nFail++;
            $display("FAIL %s: no expectation queued", name);
        end else begin
            exp = expQ.pop_front();
            if (got !== exp) begin
                nFail++;
                $display("FAIL %s: got stall=%0b fwd_a=%0d fwd_b=%0d cnt=%0d, expected stall=%0b fwd_a=%0d fwd_b=%0d cnt=%0d",
                         name, got[6], got[5:4], got[3:2], got[1:0],
                         exp[6], exp[5:4], exp[3:2], exp[1:0]);
            end
        end
    endtask

    // One cycle of dutB: drive at negedge, sample before the next posedge
    task automatic stepB(input string name, input instrT ins, input int st,
                         input int a, input int b, input int cnt);
        @(negedge clk);
        driveB(1'b0, 1'b0, ins);
        expQ.push_back({1'(st), 2'(a), 2'(b), 2'(cnt)});
        #1;
        compareB(name);
    endtask

    // ---------------- stimulus ----------------
    vecT vecs[$];

    initial begin
        rst_n = 1'b0;
        driveA(1'b0, 1'b0, nop());
        driveB(1'b0, 1'b0, nop());

        // Each row: ID instruction of the cycle and outputs expected in it
        vecs.push_back(mk("idle",          0, 0, nop(),         0, 0, 0, 0));
        vecs.push_back(mk("add_r3",        0, 0, alu(3, 1, 2),  0, 0, 0, 0));
        vecs.push_back(mk("sub_r3r3",      0, 0, alu(4, 3, 3),  0, 0, 0, 0));
        vecs.push_back(mk("b2b_fwd",       0, 0, nop(),         0, 1, 1, 0));
        vecs.push_back(mk("add_r3_b",      0, 0, alu(3, 1, 2),  0, 0, 0, 0));
        vecs.push_back(mk("nop_gap",       0, 0, nop(),         0, 0, 0, 0));
        vecs.push_back(mk("sub_r3r1",      0, 0, alu(4, 3, 1),  0, 0, 0, 0));
        vecs.push_back(mk("two_apart",     0, 0, ld(5, 1),      0, 2, 0, 0));
        vecs.push_back(mk("ld_use_stall",  0, 0, alu(6, 5, 2),  1, 0, 0, 0));
        vecs.push_back(mk("ld_use_bubble", 0, 0, alu(6, 5, 2),  0, 0, 0, 1));
        vecs.push_back(mk("ld_use_fwd",    0, 0, nop(),         0, 2, 0, 1));
        vecs.push_back(mk("add_r3_c",      0, 0, alu(3, 1, 2),  0, 0, 0, 1));
        vecs.push_back(mk("add_r3_d",      0, 0, alu(3, 1, 2),  0, 0, 0, 1));
        vecs.push_back(mk("sub_r3r3_b",    0, 0, alu(4, 3, 3),  0, 0, 0, 1));
        vecs.push_back(mk("nearest",       0, 0, alu(0, 1, 2),  0, 1, 1, 1));
        vecs.push_back(mk("sub_r0r0",      0, 0, alu(4, 0, 0),  0, 0, 0, 1));
        vecs.push_back(mk("zero_reg",      0, 0, nop(),         0, 0, 0, 1));
        vecs.push_back(mk("ld_r5",         0, 0, ld(5, 1),      0, 0, 0, 1));
        vecs.push_back(mk("ghost_r5",      0, 0, ghost(5),      0, 0, 0, 1));
        vecs.push_back(mk("early_load",    0, 0, nop(),         0, 0, 0, 1));
        vecs.push_back(mk("ld_r7",         0, 0, ld(7, 1),      0, 0, 0, 1));
        vecs.push_back(mk("hold_1",        1, 0, alu(6, 7, 7),  1, 0, 0, 1));
        vecs.push_back(mk("hold_2",        1, 0, alu(6, 7, 7),  1, 0, 0, 1));
        vecs.push_back(mk("hold_3",        1, 0, alu(6, 7, 7),  1, 0, 0, 1));
        vecs.push_back(mk("hold_release",  0, 0, alu(6, 7, 7),  1, 0, 0, 1));
        vecs.push_back(mk("hold_bubble",   0, 0, alu(6, 7, 7),  0, 0, 0, 2));
        vecs.push_back(mk("hold_fwd",      0, 0, nop(),         0, 2, 2, 2));
        vecs.push_back(mk("ld_r8",         0, 0, ld(8, 1),      0, 0, 0, 2));
        vecs.push_back(mk("flush_stall",   0, 1, alu(9, 8, 8),  0, 0, 0, 2));
        vecs.push_back(mk("sub_r9",        0, 0, alu(10, 9, 9), 0, 0, 0, 2));
        vecs.push_back(mk("flush_bubble",  0, 0, nop(),         0, 0, 0, 2));

        // Reset state
        repeat (2) @(negedge clk);
        check("reset.stall_a", ifA.stall, 0);
        check("reset.fwd_a_a", ifA.fwd_a, 0);
        check("reset.fwd_b_a", ifA.fwd_b, 0);
        check("reset.cnt_a",   ifA.stall_cnt, 0);
        check("reset.stall_b", ifB.stall, 0);
        check("reset.cnt_b",   ifB.stall_cnt, 0);
        #2 rst_n = 1'b1;

        // Table for the default build
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            driveA(vecs[i].hold, vecs[i].flush, vecs[i].ins);
            #1;
            check($sformatf("r%0d_%s.stall", i, vecs[i].name), ifA.stall,     vecs[i].expStall);
            check($sformatf("r%0d_%s.fwd_a", i, vecs[i].name), ifA.fwd_a,     vecs[i].expA);
            check($sformatf("r%0d_%s.fwd_b", i, vecs[i].name), ifA.fwd_b,     vecs[i].expB);
            check($sformatf("r%0d_%s.cnt",   i, vecs[i].name), ifA.stall_cnt, vecs[i].expCnt);
        end
        @(negedge clk);
        driveA(1'b0, 1'b0, nop());

        // NUM_STAGES=3, LOAD_STAGE=3: two stall cycles, then forward from slot 3
        stepB("b_ld_r7",      ld(7, 1),     0, 0, 0, 0);
        stepB("b_stall1",     alu(6, 7, 2), 1, 0, 0, 0);
        stepB("b_stall2",     alu(6, 7, 2), 1, 0, 0, 1);
        stepB("b_release",    alu(6, 7, 2), 0, 0, 0, 2);
        stepB("b_fwd3",       nop(),        0, 3, 0, 2);
        // A nearer non-load writer of r7 masks the older load
        stepB("b_ld_r7_m",    ld(7, 1),     0, 0, 0, 2);
        stepB("b_add_r7",     alu(7, 1, 2), 0, 0, 0, 2);
        stepB("b_mask",       alu(4, 7, 7), 0, 0, 0, 2);
        stepB("b_mask_fwd",   nop(),        0, 1, 1, 2);
        // Counter saturates at 3 in the 2-bit build
        stepB("b_ld_r7_s",    ld(7, 1),     0, 0, 0, 2);
        stepB("b_sat_stall1", alu(6, 7, 7), 1, 0, 0, 2);
        stepB("b_sat_stall2", alu(6, 7, 7), 1, 0, 0, 3);
        stepB("b_sat_hold",   alu(6, 7, 7), 0, 0, 0, 3);
        stepB("b_ld_r7_r",    ld(7, 1),     0, 3, 3, 3);
        stepB("b_pre_reset",  alu(6, 7, 7), 1, 0, 0, 3);

        // Async reset in the middle of a stall: outputs clear at once
        rst_n = 1'b0;
        #1;
        expQ.push_back(7'd0);
        compareB("b_async_reset");
        check("async_reset.stall_a", ifA.stall, 0);
        check("async_reset.cnt_a",   ifA.stall_cnt, 0);
        #1 rst_n = 1'b1;
        #1;
        expQ.push_back(7'd0);
        compareB("b_post_reset");
        stepB("b_post_reset_ex", nop(), 0, 0, 0, 0);

        check("exp_q_drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-stage forwarding control unit.
- Tracks in-flight register writers in an internal shadow pipeline, so the datapath no longer supplies stage-register fields.
- Produces per-operand forwarding selects for the EX-stage instruction, a load-use stall/bubble request for the ID stage, and a saturating stall-cycle counter.
- Sits beside the ID/EX pipeline registers of the pipelined core.

Parameters:
- REG_AW, 4: register-address width.
- NUM_STAGES, 2: forwarding source slots after EX (slot1 = EX/MEM, slot2 = MEM/WB, ...). Legal range 1..7.
- LOAD_STAGE, 2: first slot at which load data is forwardable. Legal range 1..NUM_STAGES.
- ZERO_REG, 1: when 1, register 0 is never forwarded or stalled on.
- CNT_W, 16: width of the stall counter.
- SELW, derived as clog2(NUM_STAGES+1): width of a forwarding select. Not user-set.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  global pipeline freeze (memory stall); no slot advances.
- flush  in  1  squash the ID-stage instruction (branch taken).
- id_valid  in  1  ID stage holds a real instruction.
- id_rs, id_rt  in  REG_AW  ID source registers.
- id_rs_used, id_rt_used  in  1  source is actually read.
- id_rd  in  REG_AW  ID destination.
- id_regwrite  in  1  ID instruction writes id_rd.
- id_memread  in  1  ID instruction is a load.
- stall  out  1  freeze PC/IF-ID and inject a bubble into EX.
- fwd_a, fwd_b  out  SELW  operand select for the EX instruction: 0 = register file, k = slot k.
- stall_cnt  out  CNT_W  number of load-use stall cycles, saturating.

Behaviour:
- State per slot (slot0 = EX instruction, slot1..NUM_STAGES):
  - valid, rd, regwrite, memread.
  - slot0 additionally holds rs, rt, rs_used, rt_used.
- Reset (async, rst_n low): all slot valid = 0, stall_cnt = 0. Outputs then read stall = 0, fwd_a = fwd_b = 0.
- Advance on each clk edge when hold = 0:
  - slot k <= slot k-1 for k >= 1; slot NUM_STAGES contents are discarded.
  - slot0 <= ID fields with valid = id_valid, when stall = 0 and flush = 0.
  - Otherwise slot0 <= bubble (valid = 0).
- Hold: when hold = 1, all slots keep their value and stall_cnt is unchanged. Outputs remain combinational on the held state.
- Writer match, slot k against source s: valid, regwrite, rd == s, and not (ZERO_REG and s == 0).
- Forward select (combinational from registered state), for fwd_a using slot0 rs / rs_used (fwd_b identical with rt / rt_used):
  - Take the lowest k >= 1 with a writer match.
  - If that slot is a load and k < LOAD_STAGE, select 0 (a stall has already prevented this case in legal flow).
  - Otherwise select k.
  - No match, or operand unused: select 0.
  - Nearest producer always wins; an older match is ignored.
- Stall (combinational):
  - Asserted when id_valid, flush = 0, and some used ID source has a writer match in slot j with j < LOAD_STAGE-1 (j includes slot0) and that slot's memread = 1.
  - Default LOAD_STAGE = 2: only slot0 loads cause a stall, lasting 1 cycle.
  - LOAD_STAGE = L: up to L-1 consecutive stall cycles.
  - A non-load in a nearer slot that writes the same register masks an older load.
- flush has priority over stall: stall = 0, and a bubble enters slot0.
- stall_cnt increments by 1 on each edge where stall = 1 and hold = 0. It saturates at all-ones.
- Reset deasserted mid-operation: the first post-reset cycle sees an empty pipeline, so no forwarding and no stall.

Test Plan:
- Back-to-back ALU dependency: ADD r3 then SUB r4,r3,r3, defaults. Next cycle fwd_a = fwd_b = 1, stall = 0.
- Two-apart dependency: ADD r3, NOP, SUB r4,r3,r1. fwd_a = 2, fwd_b = 0.
- Load-use: LW r5 then ADD r6,r5,r2.
  - stall = 1 for exactly 1 cycle; slot0 bubble.
  - Dependent then enters EX with fwd_a = 2.
  - stall_cnt goes 0 -> 1.
- Priority: ADD r3, ADD r3, SUB r4,r3,r3. fwd_a = 1 (nearest producer), not 2. Writes to r0 with ZERO_REG = 1: fwd = 0.
- hold/flush:
  - hold = 1 for 3 cycles during a load-use stall: slots frozen, stall_cnt unchanged.
  - flush together with a stall condition: stall = 0, bubble enters EX.
- Parametrised build NUM_STAGES = 3, LOAD_STAGE = 3, LW r7 then use:
  - 2 stall cycles, then fwd = 3.
  - Async reset asserted mid-stall: all outputs 0 immediately.
